// File: rtl/piso_serializer.sv
//------------------------------------------------------------------------------
// PisoSerializer (module piso_serializer)
//
// Purpose:
//   Parallel-in / serial-out serializer. A WIDTH-bit word is accepted through
//   a load/ready handshake and then sent one bit per clock on qout. Bit order
//   is either MSB-first or LSB-first. Every bit is qualified by qvalid, and
//   last marks the final bit of each frame. A new word can be accepted while
//   the last bit of the current frame is on qout, so frames can stream
//   back-to-back with no idle cycle between them.
//
// Parameters:
//   WIDTH      data word width in bits (1..64), default 8
//   MSB_FIRST  1 = pin[WIDTH-1] is sent first, 0 = pin[0] is sent first
//
// Optional feature (compile-time macro):
//   PISO_PARITY_EN  when defined, an even-parity bit (XOR of all pin bits)
//                   is appended after the data bits. The frame is then
//                   WIDTH+1 bits long and last marks the parity bit. When
//                   undefined, no parity logic or storage is built.
//
// Ports:
//   clk     in   rising-edge clock for all state
//   reset   in   synchronous, active-high reset (takes priority over load)
//   load    in   word-valid request, acted on only while ready=1
//   pin     in   parallel word, captured on an accepted load
//   ready   out  block can take a word this cycle (~busy | last)
//   qout    out  serial data bit (registered)
//   qvalid  out  qout carries a frame bit this cycle (registered)
//   last    out  qout is the final bit of the frame (registered)
//   busy    out  a frame is in progress (registered, same as qvalid)
//------------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pin,
  output logic             ready,
  output logic             qout,
  output logic             qvalid,
  output logic             last,
  output logic             busy
);

  // Number of bits sent per word, including the optional parity bit.
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  // The counter must be able to hold FRAME_LEN-1, which is at most WIDTH.
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Two-state controller: waiting for a word, or shifting one out.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_LEN-1:0] frame;
  logic [FRAME_LEN-1:0] sreg;
  logic                 accept;

  // The incoming word is rearranged into transmit order, with frame[0]
  // being the first bit on the wire. Doing the reordering once here lets
  // the shift register always shift toward bit 0, whichever order the
  // instance was built for. The parity bit, when present, sits at the end.
  always_comb begin
    frame = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST != 0) begin
        frame[i] = pin[WIDTH-1-i];
      end else begin
        frame[i] = pin[i];
      end
    end
`ifdef PISO_PARITY_EN
    frame[WIDTH] = ^pin;
`endif
  end

  // busy and qvalid both come straight from the state flop, so they are
  // registered outputs and always agree. ready is a function of registered
  // signals only and never of load, so the handshake has no combinational
  // path from load back to ready.
  assign busy   = (state == SHIFT);
  assign qvalid = busy;
  assign ready  = ~busy | last;
  assign accept = load & ready;

  // Main sequencer.
  // On an accepted load, the first frame bit goes straight onto qout at
  // that edge and the remaining bits are parked in sreg, already shifted
  // one place. While shifting, cnt counts the bits still to come after
  // the one on qout; when it reaches zero the bit on qout is the last one,
  // and the next edge either accepts a new word (no gap) or drops back to
  // IDLE with qout forced low. last is registered alongside qout, so it is
  // set one edge early: at the edge that moves cnt from 1 to 0, or
  // directly at accept when a frame is only one bit long.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      qout  <= 1'b0;
      last  <= 1'b0;
    end else if (accept) begin
      state <= SHIFT;
      cnt   <= CNT_START;
      qout  <= frame[0];
      sreg  <= frame >> 1;
      last  <= (FRAME_LEN == 1);
    end else if (state == SHIFT) begin
      if (cnt != '0) begin
        cnt  <= cnt - CNT_ONE;
        qout <= sreg[0];
        sreg <= sreg >> 1;
        last <= (cnt == CNT_ONE);
      end else begin
        state <= IDLE;
        qout  <= 1'b0;
        last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
//------------------------------------------------------------------------------
// tb_piso_serializer
//
// Self-checking bench for piso_serializer. Three instances are driven:
//   dut 0: WIDTH=4, MSB_FIRST=1
//   dut 1: WIDTH=4, MSB_FIRST=0
//   dut 2: WIDTH=1
// Expected frame bits are pushed to a per-instance queue when a load is
// driven that the bench's own model says will be accepted, and popped one
// per clock when outputs are sampled. An empty queue means the instance
// must be idle. PISO_PARITY_EN, if defined for the build, is honoured here
// as well.
//------------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic q;
    logic l;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load0 = 1'b0, load1 = 1'b0, load2 = 1'b0;
  logic [3:0] pin0 = '0, pin1 = '0;
  logic [0:0] pin2 = '0;
  logic       rdy0, qo0, qv0, la0, bu0;
  logic       rdy1, qo1, qv1, la1, bu1;
  logic       rdy2, qo2, qv2, la2, bu2;

  exp_t expQ0[$];
  exp_t expQ1[$];
  exp_t expQ2[$];
  logic rdyModel[3];

  int nChecks = 0;
  int nErrors = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut0 (
    .clk(clk), .reset(reset), .load(load0), .pin(pin0),
    .ready(rdy0), .qout(qo0), .qvalid(qv0), .last(la0), .busy(bu0)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut1 (
    .clk(clk), .reset(reset), .load(load1), .pin(pin1),
    .ready(rdy1), .qout(qo1), .qvalid(qv1), .last(la1), .busy(bu1)
  );

  piso_serializer #(.WIDTH(1), .MSB_FIRST(1)) dut2 (
    .clk(clk), .reset(reset), .load(load2), .pin(pin2),
    .ready(rdy2), .qout(qo2), .qvalid(qv2), .last(la2), .busy(bu2)
  );

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic actual, input logic expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %b, expected %b at t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Queue helpers, one queue per instance.
  task automatic pushExp(input int d, input exp_t e);
    case (d)
      0: expQ0.push_back(e);
      1: expQ1.push_back(e);
      default: expQ2.push_back(e);
    endcase
  endtask

  task automatic popExp(input int d, output exp_t e, output logic ev);
    e  = '0;
    ev = 1'b0;
    case (d)
      0: if (expQ0.size() > 0) begin e = expQ0.pop_front(); ev = 1'b1; end
      1: if (expQ1.size() > 0) begin e = expQ1.pop_front(); ev = 1'b1; end
      default: if (expQ2.size() > 0) begin e = expQ2.pop_front(); ev = 1'b1; end
    endcase
  endtask

  // Compares one instance against the next scoreboard entry (or idle).
  task automatic checkDut(input int d, input logic qv, input logic qo,
                          input logic la, input logic bu, input logic rd);
    exp_t e;
    logic ev;
    popExp(d, e, ev);
    checkOutput($sformatf("dut%0d qvalid", d), qv, ev);
    checkOutput($sformatf("dut%0d qout", d), qo, e.q);
    checkOutput($sformatf("dut%0d last", d), la, e.l);
    checkOutput($sformatf("dut%0d busy", d), bu, ev);
    checkOutput($sformatf("dut%0d ready", d), rd, !ev || e.l);
    rdyModel[d] = !ev || e.l;
  endtask

  // Advance one clock and sample all instances 2 units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
    checkDut(0, qv0, qo0, la0, bu0, rdy0);
    checkDut(1, qv1, qo1, la1, bu1, rdy1);
    checkDut(2, qv2, qo2, la2, bu2, rdy2);
  endtask

  // Drive load/pin for one instance; if the model says the word will be
  // accepted at the coming edge, queue its expected bits in wire order.
  task automatic applyStimulus(input int d, input logic ld, input logic [3:0] p);
    int   w;
    logic msb;
    logic par;
    exp_t e;
    w   = (d == 2) ? 1 : 4;
    msb = (d != 1);
    case (d)
      0: begin load0 = ld; pin0 = p; end
      1: begin load1 = ld; pin1 = p; end
      default: begin load2 = ld; pin2 = p[0]; end
    endcase
    if (ld && rdyModel[d] && !reset) begin
      par = 1'b0;
      for (int k = 0; k < w; k++) begin
        par ^= p[k];
        e.q = msb ? p[w-1-k] : p[k];
        e.l = (k == w - 1) && !PAR_EN;
        pushExp(d, e);
      end
      if (PAR_EN) begin
        e.q = par;
        e.l = 1'b1;
        pushExp(d, e);
      end
    end
  endtask

  task automatic doReset(input logic r);
    reset = r;
    if (r) begin
      expQ0.delete();
      expQ1.delete();
      expQ2.delete();
      for (int d = 0; d < 3; d++) rdyModel[d] = 1'b1;
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) rdyModel[d] = 1'b1;
    $display("[TB] start, parity=%0d", PAR_EN);

    // Reset state.
    doReset(1'b1);
    tick();
    tick();
    doReset(1'b0);
    tick();

    // Single MSB-first frame 1011, then idle.
    applyStimulus(0, 1'b1, 4'b1011);
    tick();
    applyStimulus(0, 1'b0, 4'b0000);
    for (int i = 0; i < 7; i++) tick();

    // Back-to-back 1011 then 1001 with load held; pin changes mid-frame.
    applyStimulus(0, 1'b1, 4'b1011);
    for (int i = 0; i < 5; i++) begin
      tick();
      applyStimulus(0, 1'b1, 4'b1001);
    end
    tick();
    applyStimulus(0, 1'b0, 4'b0000);
    for (int i = 0; i < 8; i++) tick();

    // LSB-first 1011, with a load of 0110 while ready is low (ignored).
    applyStimulus(1, 1'b1, 4'b1011);
    tick();
    applyStimulus(1, 1'b0, 4'b0000);
    tick();
    applyStimulus(1, 1'b1, 4'b0110);
    tick();
    applyStimulus(1, 1'b0, 4'b0000);
    for (int i = 0; i < 7; i++) tick();

    // Reset during bit 2 of a 1011 frame, then a fresh 1001 frame.
    applyStimulus(0, 1'b1, 4'b1011);
    tick();
    applyStimulus(0, 1'b0, 4'b0000);
    tick();
    tick();
    doReset(1'b1);
    tick();
    doReset(1'b0);
    applyStimulus(0, 1'b1, 4'b1001);
    tick();
    applyStimulus(0, 1'b0, 4'b0000);
    for (int i = 0; i < 7; i++) tick();

    // WIDTH=1 streaming 1,0,1 with load held high.
    applyStimulus(2, 1'b1, 4'b0001);
    tick();
    applyStimulus(2, 1'b1, 4'b0000);
    tick();
    applyStimulus(2, 1'b1, 4'b0001);
    tick();
    applyStimulus(2, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
